mode_decoder: RTL

MODE_DECODER -- requirements
Module: mode_decoder

---
 rtl/mode_decoder_pkg.sv | 29 ++
 rtl/mode_debounce.sv | 44 ++++
 rtl/mode_decoder.sv | 122 ++++++++++++
 3 files changed

// File: rtl/mode_decoder_pkg.sv
// mode_decoder_pkg: shared definitions for the mode decoder.
//   - bit positions of the fields inside the 9-bit control word
//   - FSM state encoding (plain localparams so older tools can consume it)
//   - default highest legal mode value
//   - helper that tells whether a control word is legal
package mode_decoder_pkg;

  localparam int WORD_W           = 9;
  localparam int COLOR_HI         = 8;
  localparam int COLOR_LO         = 7;
  localparam int MODE_HI          = 6;
  localparam int MODE_LO          = 3;
  localparam int RSVD_BIT         = 2;
  localparam int DISP_HI          = 1;
  localparam int DISP_LO          = 0;
  localparam int MODE_MAX_DEFAULT = 11;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_PEND   = 2'd1;
  localparam logic [1:0] ST_SWITCH = 2'd2;
  localparam logic [1:0] ST_APPLY  = 2'd3;

  // Reserved bit must be clear and the mode must not exceed mode_max.
  function automatic logic word_valid(input logic [WORD_W-1:0] w,
                                      input logic [3:0]        mode_max);
    return !w[RSVD_BIT] && (w[MODE_HI:MODE_LO] <= mode_max);
  endfunction

endpackage

// File: rtl/mode_debounce.sv
// mode_debounce: 2-flop synchronizer followed by a stability counter.
//   clk, rst_n : clock, asynchronous active-low reset
//   din        : asynchronous input word
//   dout       : synchronized word
//   stable     : one-cycle pulse when dout has held for STABLE_CYCLES cycles
module mode_debounce #(
  parameter int WIDTH         = 9,
  parameter int STABLE_CYCLES = 1_000_000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             stable
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);

  logic [WIDTH-1:0] s1, s2;
  logic [CW-1:0]    cnt;

  // s1 != s2 means dout changes on this edge, so the count restarts at 0
  // on the same cycle the new word appears. stable fires only on the
  // transition into saturation, hence exactly once per word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1     <= '0;
      s2     <= '0;
      cnt    <= '0;
      stable <= 1'b0;
    end else begin
      s1     <= din;
      s2     <= s1;
      stable <= (s1 == s2) && (cnt == CW'(STABLE_CYCLES - 1));
      if (s1 != s2)
        cnt <= '0;
      else if (cnt != CW'(STABLE_CYCLES))
        cnt <= cnt + 1'b1;
    end
  end

  assign dout = s2;

endmodule

// File: rtl/mode_decoder.sv
// mode_decoder: debounces an asynchronous 9-bit control word and applies its
// color/mode/display fields on a frame boundary, requesting a camera switch
// first when the display field changes.
//   clk, i_rst_n      : clock, asynchronous active-low reset
//   i_im_p            : control word {color[1:0], mode[3:0], rsvd, display[1:0]}
//   i_frame_start     : frame start pulse
//   i_cam_switch_ack  : camera mux acknowledge
//   o_color/o_mode/o_display : applied fields
//   o_update          : pulse when applied fields are loaded
//   o_reject          : pulse when an illegal word becomes stable
//   o_cam_switch_req  : level request, held until acknowledged
//   o_busy            : FSM in PEND, SWITCH or APPLY
//   o_err_count       : saturating reject counter, only with MODE_DECODER_ERRCNT_EN
module mode_decoder import mode_decoder_pkg::*; #(
  parameter int STABLE_CYCLES = 1_000_000,
  parameter int MODE_MAX      = MODE_MAX_DEFAULT
) (
  input  logic       clk,
  input  logic       i_rst_n,
  input  logic [8:0] i_im_p,
  input  logic       i_frame_start,
  input  logic       i_cam_switch_ack,
  output logic [1:0] o_color,
  output logic [3:0] o_mode,
  output logic [1:0] o_display,
  output logic       o_update,
  output logic       o_reject,
  output logic       o_cam_switch_req,
  output logic       o_busy
`ifdef MODE_DECODER_ERRCNT_EN
  ,
  output logic [7:0] o_err_count
`endif
);

  logic [WORD_W-1:0] word, latched;
  logic              stable, valid;
  logic [1:0]        state, state_n;
  logic [7:0]        cur_fields, app_fields;

  mode_debounce #(
    .WIDTH         (WORD_W),
    .STABLE_CYCLES (STABLE_CYCLES)
  ) u_debounce (
    .clk    (clk),
    .rst_n  (i_rst_n),
    .din    (i_im_p),
    .dout   (word),
    .stable (stable)
  );

  assign valid      = word_valid(word, 4'(MODE_MAX));
  assign cur_fields = {word[COLOR_HI:COLOR_LO], word[MODE_HI:MODE_LO], word[DISP_HI:DISP_LO]};
  assign app_fields = {o_color, o_mode, o_display};

  // Frame starts are ignored in IDLE, so a frame start coinciding with
  // IDLE->PEND is never consumed. In PEND an input change wins over a
  // simultaneous frame start.
  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:
        if (stable && valid && (cur_fields != app_fields)) state_n = ST_PEND;
      ST_PEND:
        if (word != latched)
          state_n = ST_IDLE;
        else if (i_frame_start)
          state_n = (latched[DISP_HI:DISP_LO] != o_display) ? ST_SWITCH : ST_APPLY;
      ST_SWITCH:
        if (i_cam_switch_ack) state_n = ST_APPLY;
      ST_APPLY:
        state_n = ST_IDLE;
      default:
        state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state            <= ST_IDLE;
      latched          <= '0;
      o_color          <= '0;
      o_mode           <= '0;
      o_display        <= '0;
      o_update         <= 1'b0;
      o_reject         <= 1'b0;
      o_cam_switch_req <= 1'b0;
      o_busy           <= 1'b0;
    end else begin
      state    <= state_n;
      o_busy   <= (state_n != ST_IDLE);
      o_update <= 1'b0;
      o_reject <= stable && !valid;

      if (state == ST_IDLE && state_n == ST_PEND)
        latched <= word;

      if (state == ST_PEND && state_n == ST_SWITCH)
        o_cam_switch_req <= 1'b1;
      else if (state == ST_SWITCH && i_cam_switch_ack)
        o_cam_switch_req <= 1'b0;

      if (state == ST_APPLY) begin
        o_color   <= latched[COLOR_HI:COLOR_LO];
        o_mode    <= latched[MODE_HI:MODE_LO];
        o_display <= latched[DISP_HI:DISP_LO];
        o_update  <= 1'b1;
      end
    end
  end

`ifdef MODE_DECODER_ERRCNT_EN
  // Counts in step with o_reject being set.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n)
      o_err_count <= '0;
    else if (stable && !valid && o_err_count != 8'hFF)
      o_err_count <= o_err_count + 8'd1;
  end
`endif

endmodule
